sram_port_arb: RTL
==================

// Module: sram_port_arb
// PURPOSE
//  Two-requester arbiter sharing one single-port synchronous SRAM (TCM macro, ADDR/WDATA/WREN/CS/RDATA style).
//  Sits between two SRAM-side masters (e.g. AHB-to-SRAM bridge and a DMA/boot loader) and one TCM instance.
//  Round-robin grant with optional bounded lock for back-to-back bursts; routes 1-cycle read data back to issuer.
// PARAMETERS
//  AW        13  SRAM word address width
//  DW        32  data width; byte enables = DW/8
//  MAX_HOLD  8   max consecutive locked grants to one requester before forced release (1..255)
// PORTS
//  sys_root_clk   in   1      clock
//  sys_root_rstn  in   1      async active-low reset
//  reqN_valid     in   1      N=0,1: access request
//  reqN_ready     out  1      access accepted this cycle (valid&ready = issued)
//  reqN_lock      in   1      keep grant for next access
//  reqN_addr      in   AW     word address
//  reqN_wen       in   DW/8   byte write enables; 0 = read
//  reqN_wdata     in   DW     write data
//  reqN_rvalid    out  1      read data valid (1 cycle after read issue)
//  reqN_rdata     out  DW     read data (= sram_rdata; meaningful only with rvalid)
//  sram_cs        out  1      SRAM chip select
//  sram_addr      out  AW     SRAM address
//  sram_wen       out  DW/8   SRAM byte write enables
//  sram_wdata     out  DW     SRAM write data
//  sram_rdata     in   DW     SRAM read data, valid cycle after cs with wen==0
// BEHAVIOUR
//  - Reset: all outputs 0; last_grant=1 (req0 wins first conflict); owner=none; hold_cnt=0; rd_pend=0.
//  - Grant combinational, same cycle: at most one reqN_ready high; ready only when that valid high.
//  - SRAM outputs mux from granted requester; sram_cs=1 iff a grant issued; idle: cs=0, wen=0, addr/wdata=0.
//  - Arbitration, no lock owner: one valid -> grant it; both valid -> grant !last_grant.
//    last_grant <= granted id on every issue.
//  - Lock: issue with reqN_lock=1 makes N owner; while owner set and hold_cnt<MAX_HOLD, only owner may be
//    granted, other requester stalls (ready=0) even if owner idle.
//  - Owner released when: owner issues with lock=0; owner valid low for a cycle; or hold_cnt==MAX_HOLD.
//    Release on that same cycle/edge; next arbitration is round-robin.
//  - hold_cnt: 0 when no owner; +1 per owner issue while locked; saturates at MAX_HOLD.
//    At MAX_HOLD lock ignored, owner cleared, last_grant=owner so other wins conflict.
//  - Read pipeline: read issue -> rd_pend<=1, rd_id<=N; next cycle reqN_rvalid=1 for rd_id, 0 for other.
//    Back-to-back reads every cycle supported, full throughput, no bubble.
//  - Write: no response; write then read same addr on following cycles returns new data (SRAM ordering).
//  - Simultaneous read return (prev cycle) and new issue: both allowed same cycle.
//  - Async reset mid-op: pending read dropped (no rvalid), owner cleared, counters cleared immediately.
//  - X-free: wen/addr from a non-granted requester never reach SRAM.
// TESTING
//  1. req0 read addr 0x10 alone -> ready0=1 same cycle, sram_cs=1 addr=0x10 wen=0; next cycle rvalid0=1, rvalid1=0.
//  2. both valid continuously, lock=0 -> grants alternate 0,1,0,1; first cycle after reset grants req0.
//  3. req1 lock=1 for 20 accesses, req0 valid, MAX_HOLD=8 -> req1 gets 8 grants, then req0 granted, then alternate.
//  4. req0 write 0xA5A5A5A5 wen=4'hF addr 5 then req1 read addr 5 -> rvalid1 with rdata=0xA5A5A5A5.
//  5. interleaved reads req0@1, req1@2, req0@3 back-to-back -> rvalid pulses route to 0,1,0 on consecutive cycles.
//  6. assert rstn low cycle after a read issue -> no rvalid; all outputs 0; first post-reset conflict goes to req0.

Source files
------------

// File: rtl/sram_port_arb.sv
// Two-requester round-robin arbiter in front of one single-port synchronous SRAM.
// Supports a bounded lock for back-to-back bursts and routes 1-cycle read data back to the issuer.
module sram_port_arb #(
  parameter int unsigned AW       = 13,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            sys_root_clk,
  input  logic            sys_root_rstn,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_lock,
  input  logic [AW-1:0]   req0_addr,
  input  logic [DW/8-1:0] req0_wen,
  input  logic [DW-1:0]   req0_wdata,
  output logic            req0_rvalid,
  output logic [DW-1:0]   req0_rdata,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_lock,
  input  logic [AW-1:0]   req1_addr,
  input  logic [DW/8-1:0] req1_wen,
  input  logic [DW-1:0]   req1_wdata,
  output logic            req1_rvalid,
  output logic [DW-1:0]   req1_rdata,

  output logic            sram_cs,
  output logic [AW-1:0]   sram_addr,
  output logic [DW/8-1:0] sram_wen,
  output logic [DW-1:0]   sram_wdata,
  input  logic [DW-1:0]   sram_rdata
);

  localparam int unsigned BW         = DW / 8;
  localparam logic [7:0]  MAX_HOLD_C = 8'(MAX_HOLD);

  logic          last_grant_q, last_grant_d;
  logic          owner_vld_q,  owner_vld_d;
  logic          owner_id_q,   owner_id_d;
  logic [7:0]    hold_cnt_q,   hold_cnt_d;
  logic          rd_pend_q,    rd_pend_d;
  logic          rd_id_q,      rd_id_d;

  logic          locked;
  logic          owner_req_vld;
  logic          gnt_vld;
  logic          gnt_id;
  logic          gnt_lock;

  // Grant decision: a live lock shuts the other requester out even while the owner is idle.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    gnt_vld       = 1'b0;
    gnt_id        = 1'b0;
    locked        = owner_vld_q && (hold_cnt_q < MAX_HOLD_C);
    owner_req_vld = owner_id_q ? req1_valid : req0_valid;
    if (locked) begin
      gnt_vld = owner_req_vld;
      gnt_id  = owner_id_q;
    end else if (req0_valid && req1_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = ~last_grant_q;
    end else if (req0_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b0;
    end else if (req1_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end
  end

  assign req0_ready = gnt_vld && !gnt_id;
  assign req1_ready = gnt_vld &&  gnt_id;

  // The non-granted requester's fields are masked so they never reach the macro.
  always_comb begin
    sram_cs    = gnt_vld;
    sram_addr  = '0;
    sram_wen   = '0;
    sram_wdata = '0;
    gnt_lock   = 1'b0;
    if (gnt_vld) begin
      sram_addr  = gnt_id ? req1_addr  : req0_addr;
      sram_wen   = gnt_id ? req1_wen   : req0_wen;
      sram_wdata = gnt_id ? req1_wdata : req0_wdata;
      gnt_lock   = gnt_id ? req1_lock  : req0_lock;
    end
  end

  always_comb begin
    last_grant_d = gnt_vld ? gnt_id : last_grant_q;
    owner_vld_d  = owner_vld_q;
    owner_id_d   = owner_id_q;
    hold_cnt_d   = hold_cnt_q;
    if (owner_vld_q) begin
      // While locked and the owner is present it is always the one granted.
      if (locked && owner_req_vld && gnt_lock) begin
        hold_cnt_d = hold_cnt_q + 8'd1;
      end else begin
        owner_vld_d = 1'b0;
        owner_id_d  = 1'b0;
        hold_cnt_d  = 8'd0;
      end
    end else if (gnt_vld && gnt_lock) begin
      owner_vld_d = 1'b1;
      owner_id_d  = gnt_id;
      hold_cnt_d  = 8'd1;
    end
    rd_pend_d = gnt_vld && (sram_wen == {BW{1'b0}});
    rd_id_d   = gnt_id;
  end

  always_ff @(posedge sys_root_clk or negedge sys_root_rstn) begin
    if (!sys_root_rstn) begin
      last_grant_q <= 1'b1;
      owner_vld_q  <= 1'b0;
      owner_id_q   <= 1'b0;
      hold_cnt_q   <= 8'd0;
      rd_pend_q    <= 1'b0;
      rd_id_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      last_grant_q <= last_grant_d;
      owner_vld_q  <= owner_vld_d;
      owner_id_q   <= owner_id_d;
      hold_cnt_q   <= hold_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_id_q      <= rd_id_d;
    end
  end

  // Read data is held at zero outside its valid cycle so all outputs are quiet in reset.
  assign req0_rvalid = rd_pend_q && !rd_id_q;
  assign req1_rvalid = rd_pend_q &&  rd_id_q;
  assign req0_rdata  = req0_rvalid ? sram_rdata : '0;
  assign req1_rdata  = req1_rvalid ? sram_rdata : '0;

endmodule
